fdc_seek: RTL and testbench
===========================

# fdc_seek

Controller-side head positioning engine for the FDD subsystem. Executes Type-I style commands (restore, seek, step, step-in, step-out) by driving the drive's STEPn/SDIRn lines with correctly spaced pulses, tracking the controller's track register, and sampling TRACK0n. It sits between the FDC command decoder and the drive interface and talks to the drive track model, which expects at least 3 ms between steps.

## Interface

Parameters:
- STEP_PULSE_CLKS, 8: STEPn low width, in clk cycles (≥2).
- SETTLE_MS, 15: head settle delay after motion, in ms.
- RESTORE_LIMIT, 255: maximum step-out pulses for restore before error.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- msclk  in  1  one-cycle 1 ms tick.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_op  in  3  seek_cmd_t: RESTORE, SEEK, STEP, STEP_IN, STEP_OUT.
- cmd_rate  in  2  step rate select: 0→6, 1→12, 2→20, 3→30 ms.
- cmd_update  in  1  STEP/STEP_IN/STEP_OUT update track_reg.
- cmd_settle  in  1  apply SETTLE_MS at the end of the command.
- cmd_target  in  8  destination track for SEEK.
- TRACK0n  in  1  low = head at track 0.
- STEPn  out  1  step pulse, active low.
- SDIRn  out  1  1 = step in (track+1), 0 = step out.
- track_reg  out  8  controller track register.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion strobe.
- error  out  1  restore failed; valid with done, held until the next accept.

## Operation

- Reset values: STEPn=1, SDIRn=0, track_reg=0, busy=0, done=0, error=0, cmd_ready=1, state IDLE. Reset mid-pulse releases STEPn in the next cycle.
- Command fields are latched on accept, and busy rises on the next cycle. The direction held from the last step is used for STEP.
- States: IDLE → SETUP → PULSE → RATE → CHECK → (SETUP | SETTLE | DONE) → IDLE.
- SETUP: decide whether a step is needed and set SDIRn. Stay in SETUP for exactly one cycle before PULSE, so SDIRn is stable before STEPn falls.
- PULSE: STEPn=0 for STEP_PULSE_CLKS cycles. On exit, update track_reg by ±1 when required.
- RATE: wait for the selected number of msclk ticks, counted after PULSE exits.
- RESTORE: if TRACK0n=0 in SETUP, set track_reg=0 and finish with no pulse. Otherwise step out, checking TRACK0n in each CHECK. When TRACK0n=0, set track_reg=0. After RESTORE_LIMIT pulses without TRACK0n, set error=1 and leave track_reg unchanged.
- SEEK: in SETUP, if track_reg==cmd_target, finish. Otherwise set SDIRn=(cmd_target>track_reg), pulse, update track_reg by ±1, and loop.
- STEP / STEP_IN / STEP_OUT: one pulse only; the direction is held, 1 or 0 respectively. If cmd_update is set, track_reg changes by ±1 with 8-bit saturation (0 and 255 are not wrapped).
- STEP_OUT, or STEP with SDIRn=0, while TRACK0n=0: no pulse, track_reg←0 regardless of cmd_update.
- SETTLE: if cmd_settle is set, wait SETTLE_MS msclk ticks before DONE.
- DONE: done=1 for one cycle, then busy=0 and cmd_ready=1 in the following cycle.
- cmd_valid while busy is ignored; it is not queued.

## Timing

- Accept at cycle 0: busy=1 at cycle 1, SETUP at cycle 1, first STEPn fall at cycle 2.
- STEPn is low for exactly STEP_PULSE_CLKS cycles.
- Successive falling edges are separated by STEP_PULSE_CLKS + 1 setup cycle + N msclk ticks (N = rate ms). The gap is always > N−1 ms, which satisfies the drive's 3 ms lockout.
- An msclk tick in the same cycle that RATE is entered is not counted.
- A zero-motion SEEK or RESTORE without settle gives done at cycle 3.

## Structure

- Package fdc_pkg: seek_cmd_t enum, the step-rate ms lookup (6/12/20/30), and the state enum.
- One sub-module, ms_delay: load an 8-bit count, decrement on msclk, assert expired. It is shared by RATE and SETTLE.
- Everything else lives in fdc_seek: FSM, pulse counter, restore step counter.

## Test plan

- Restore from track 5, drive model stepping out, rate 0 → 5 STEPn pulses with SDIRn=0, track_reg=0, error=0, done once.
- SEEK 10 from track_reg 3, rate 1 → 7 pulses with SDIRn=1 and falling edges ≥11 ms apart, track_reg=10.
- SEEK 2 from 7, then SEEK 2 again → 5 step-out pulses; the second command produces done at cycle 3 with no pulse.
- Restore with TRACK0n stuck high → 255 pulses, error=1, track_reg unchanged.
- STEP_OUT with TRACK0n=0 and cmd_update=0 → no pulse, track_reg=0. STEP_IN at track_reg=255 with cmd_update=1 → one pulse, track_reg stays 255.
- Reset asserted while STEPn is low mid-seek → STEPn=1 next cycle, all outputs at reset values, cmd_ready=1.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared types for the floppy head positioning engine: command codes, FSM
// states and the step-rate lookup.
package fdc_pkg;

  typedef enum logic [2:0] {
    CMD_RESTORE  = 3'd0,
    CMD_SEEK     = 3'd1,
    CMD_STEP     = 3'd2,
    CMD_STEP_IN  = 3'd3,
    CMD_STEP_OUT = 3'd4
  } seek_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_RATE,
    ST_CHECK,
    ST_SETTLE,
    ST_DONE
  } state_t;

  function automatic logic [7:0] rate_ms(input logic [1:0] sel);
    logic [7:0] ms;
    case (sel)
      2'd0:    ms = 8'd6;
      2'd1:    ms = 8'd12;
      2'd2:    ms = 8'd20;
      default: ms = 8'd30;
    endcase
    return ms;
  endfunction

endpackage

// File: rtl/fdc_seek_ms_delay.sv
// Millisecond down-counter shared by the step-rate wait and the head settle wait.
// A load takes priority over a tick arriving in the same cycle.
module ms_delay (
  input  logic       clk,
  input  logic       reset,
  input  logic       msclk,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (msclk && count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign expired = (count_reg == 8'd0);

endmodule

// File: rtl/fdc_seek.sv
// Head positioning engine: runs restore/seek/step commands, spaces STEPn pulses
// by the selected step rate and keeps the controller track register.
module fdc_seek
  import fdc_pkg::*;
#(
  parameter int STEP_PULSE_CLKS = 8,
  parameter int SETTLE_MS       = 15,
  parameter int RESTORE_LIMIT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msclk,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rate,
  input  logic       cmd_update,
  input  logic       cmd_settle,
  input  logic [7:0] cmd_target,
  input  logic       TRACK0n,
  output logic       STEPn,
  output logic       SDIRn,
  output logic [7:0] track_reg,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int PCW = $clog2(STEP_PULSE_CLKS + 1);

  state_t     state_reg;
  seek_cmd_t  op_reg;
  logic [1:0] rate_reg;
  logic       update_reg;
  logic       settle_reg;
  logic [7:0] target_reg;
  logic       finish_reg;
  logic       first_reg;
  logic [PCW-1:0] pulse_cnt_reg;
  logic [8:0] restore_cnt_reg;

  logic       dly_load;
  logic [7:0] dly_val;
  logic       dly_expired;
  logic       check_finish;

  // Hold the current direction when the head is already on target so that a
  // later plain STEP still uses the direction of the last real step.
  function automatic logic seek_dir(input logic [7:0] tgt, input logic [7:0] trk,
                                    input logic held);
    if (tgt > trk)      return 1'b1;
    else if (tgt < trk) return 1'b0;
    else                return held;
  endfunction

  // Loading in the first wait cycle discards any tick coincident with entry.
  assign dly_load = first_reg && (state_reg == ST_RATE || state_reg == ST_SETTLE);
  assign dly_val  = (state_reg == ST_SETTLE) ? 8'(SETTLE_MS) : rate_ms(rate_reg);

  ms_delay u_delay (
    .clk      (clk),
    .reset    (reset),
    .msclk    (msclk),
    .load     (dly_load),
    .load_val (dly_val),
    .expired  (dly_expired)
  );

  always_comb begin
    check_finish = finish_reg;
    if (op_reg == CMD_RESTORE &&
        (!TRACK0n || restore_cnt_reg >= 9'(RESTORE_LIMIT))) begin
      check_finish = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      op_reg          <= CMD_RESTORE;
      rate_reg        <= '0;
      update_reg      <= 1'b0;
      settle_reg      <= 1'b0;
      target_reg      <= '0;
      finish_reg      <= 1'b0;
      first_reg       <= 1'b0;
      pulse_cnt_reg   <= '0;
      restore_cnt_reg <= '0;
      cmd_ready       <= 1'b1;
      STEPn           <= 1'b1;
      SDIRn           <= 1'b0;
      track_reg       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_reg          <= seek_cmd_t'(cmd_op);
            rate_reg        <= cmd_rate;
            update_reg      <= cmd_update;
            settle_reg      <= cmd_settle;
            target_reg      <= cmd_target;
            finish_reg      <= 1'b0;
            restore_cnt_reg <= '0;
            error           <= 1'b0;
            busy            <= 1'b1;
            cmd_ready       <= 1'b0;
            state_reg       <= ST_SETUP;
            // Direction is settled during SETUP, one cycle before STEPn falls.
            case (cmd_op)
              CMD_RESTORE:  SDIRn <= 1'b0;
              CMD_SEEK:     SDIRn <= seek_dir(cmd_target, track_reg, SDIRn);
              CMD_STEP_IN:  SDIRn <= 1'b1;
              CMD_STEP_OUT: SDIRn <= 1'b0;
              default:      SDIRn <= SDIRn;
            endcase
          end
        end

        ST_SETUP: begin
          state_reg     <= ST_PULSE;
          STEPn         <= 1'b0;
          pulse_cnt_reg <= '0;
          case (op_reg)
            CMD_RESTORE: begin
              if (!TRACK0n) begin
                track_reg  <= '0;
                finish_reg <= 1'b1;
                STEPn      <= 1'b1;
                state_reg  <= ST_CHECK;
              end
            end
            CMD_SEEK: begin
              if (track_reg == target_reg) begin
                finish_reg <= 1'b1;
                STEPn      <= 1'b1;
                state_reg  <= ST_CHECK;
              end
            end
            CMD_STEP, CMD_STEP_IN, CMD_STEP_OUT: begin
              finish_reg <= 1'b1;
              if (!SDIRn && !TRACK0n) begin
                track_reg <= '0;
                STEPn     <= 1'b1;
                state_reg <= ST_CHECK;
              end
            end
            default: begin
              finish_reg <= 1'b1;
              STEPn      <= 1'b1;
              state_reg  <= ST_CHECK;
            end
          endcase
        end

        ST_PULSE: begin
          if (pulse_cnt_reg == PCW'(STEP_PULSE_CLKS - 1)) begin
            STEPn     <= 1'b1;
            first_reg <= 1'b1;
            state_reg <= ST_RATE;
            case (op_reg)
              CMD_RESTORE: restore_cnt_reg <= restore_cnt_reg + 9'd1;
              CMD_SEEK:    track_reg <= SDIRn ? track_reg + 8'd1 : track_reg - 8'd1;
              default: begin
                if (update_reg) begin
                  if (SDIRn && track_reg != 8'd255)      track_reg <= track_reg + 8'd1;
                  else if (!SDIRn && track_reg != 8'd0)  track_reg <= track_reg - 8'd1;
                end
              end
            endcase
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + PCW'(1);
          end
        end

        ST_RATE: begin
          if (first_reg)        first_reg <= 1'b0;
          else if (dly_expired) state_reg <= ST_CHECK;
        end

        ST_CHECK: begin
          if (check_finish) begin
            if (op_reg == CMD_RESTORE && !finish_reg) begin
              if (!TRACK0n) track_reg <= '0;
              else          error     <= 1'b1;
            end
            first_reg <= 1'b1;
            if (settle_reg) begin
              state_reg <= ST_SETTLE;
            end else begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end
          end else begin
            if (op_reg == CMD_SEEK) SDIRn <= seek_dir(target_reg, track_reg, SDIRn);
            state_reg <= ST_SETUP;
          end
        end

        ST_SETTLE: begin
          if (first_reg) begin
            first_reg <= 1'b0;
          end else if (dly_expired) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end
        end

        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdc_seek.sv
// Scoreboard bench for fdc_seek: commands push expected results, a monitor
// checks them on done, and a simple drive model follows the STEPn pulses.
module tb_fdc_seek;
  import fdc_pkg::*;

  localparam int MS_CLKS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       msclk = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_rate = 2'd0;
  logic       cmd_update = 1'b0;
  logic       cmd_settle = 1'b0;
  logic [7:0] cmd_target = 8'd0;
  logic       TRACK0n;
  logic       STEPn;
  logic       SDIRn;
  logic [7:0] track_reg;
  logic       busy;
  logic       done;
  logic       error;

  fdc_seek #(.STEP_PULSE_CLKS(8), .SETTLE_MS(15), .RESTORE_LIMIT(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .msclk      (msclk),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rate   (cmd_rate),
    .cmd_update (cmd_update),
    .cmd_settle (cmd_settle),
    .cmd_target (cmd_target),
    .TRACK0n    (TRACK0n),
    .STEPn      (STEPn),
    .SDIRn      (SDIRn),
    .track_reg  (track_reg),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (MS_CLKS - 1) @(posedge clk);
      #1 msclk = 1'b1;
      @(posedge clk);
      #1 msclk = 1'b0;
    end
  end

  // Drive model: head position moves on each STEPn falling edge.
  int pos = 0;
  bit stuck = 1'b0;
  assign TRACK0n = stuck ? 1'b1 : ((pos == 0) ? 1'b0 : 1'b1);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int   pulses, bad_dir, bad_width, min_gap, last_fall, low_run, accept_cyc;
  logic exp_dir;
  logic prev_step = 1'b1;

  always @(negedge clk) begin
    if (prev_step && !STEPn) begin
      pulses++;
      if (SDIRn !== exp_dir) bad_dir++;
      if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
      last_fall = cyc;
      if (SDIRn) begin
        if (pos < 255) pos++;
      end else if (pos > 0) begin
        pos--;
      end
    end
    if (!STEPn) low_run++;
    else if (low_run != 0) begin
      if (low_run != 8) bad_width++;
      low_run = 0;
    end
    prev_step = STEPn;
  end

  typedef struct {
    string name;
    int    pulses;
    int    track;
    int    err;
    int    lat;
    int    gap;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lim);
    end
  endtask

  // Monitor: pops one expectation per done strobe.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with no command pending, expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, ".track"},  int'(track_reg), e.track);
        check({e.name, ".error"},  int'(error),     e.err);
        check({e.name, ".pulses"}, pulses,          e.pulses);
        check({e.name, ".dir"},    bad_dir,         0);
        check({e.name, ".width"},  bad_width,       0);
        if (e.lat >= 0) check({e.name, ".latency"}, cyc - accept_cyc, e.lat);
        if (e.gap > 0)  check_ge({e.name, ".gap"}, min_gap, e.gap);
        $display("txn %s: track=%0d error=%0d pulses=%0d min_gap=%0d", e.name,
                 track_reg, error, pulses, min_gap);
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [1:0] rate,
                       input logic upd, input logic stl, input logic [7:0] tgt,
                       input logic dir, input int e_pulses, input int e_track,
                       input int e_err, input int e_lat, input int e_gap, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    cmd_op     = op;
    cmd_rate   = rate;
    cmd_update = upd;
    cmd_settle = stl;
    cmd_target = tgt;
    exp_dir    = dir;
    pulses     = 0;
    bad_dir    = 0;
    bad_width  = 0;
    low_run    = 0;
    min_gap    = 1000000;
    last_fall  = -1;
    e.name = name; e.pulses = e_pulses; e.track = e_track;
    e.err = e_err; e.lat = e_lat; e.gap = e_gap;
    if (push) sbq.push_back(e);
    accept_cyc = cyc;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || !cmd_ready) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40000) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".STEPn"},     int'(STEPn),     1);
    check({name, ".SDIRn"},     int'(SDIRn),     0);
    check({name, ".track_reg"}, int'(track_reg), 0);
    check({name, ".busy"},      int'(busy),      0);
    check({name, ".done"},      int'(done),      0);
    check({name, ".error"},     int'(error),     0);
    check({name, ".cmd_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    pos = 5;
    issue("restore5", CMD_RESTORE, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 5, 0, 0, -1, 40, 1'b1);
    wait_idle("restore5");
    issue("seek3", CMD_SEEK, 2'd0, 1'b0, 1'b0, 8'd3, 1'b1, 3, 3, 0, -1, 0, 1'b1);
    wait_idle("seek3");
    issue("seek10", CMD_SEEK, 2'd1, 1'b0, 1'b0, 8'd10, 1'b1, 7, 10, 0, -1, 11 * MS_CLKS, 1'b1);
    wait_idle("seek10");
    issue("seek7", CMD_SEEK, 2'd0, 1'b0, 1'b0, 8'd7, 1'b0, 3, 7, 0, -1, 0, 1'b1);
    wait_idle("seek7");
    issue("seek2", CMD_SEEK, 2'd0, 1'b0, 1'b0, 8'd2, 1'b0, 5, 2, 0, -1, 0, 1'b1);
    wait_idle("seek2");
    issue("seek2_again", CMD_SEEK, 2'd0, 1'b0, 1'b0, 8'd2, 1'b0, 0, 2, 0, 3, 0, 1'b1);
    wait_idle("seek2_again");

    stuck = 1'b1;
    issue("restore_stuck", CMD_RESTORE, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 255, 2, 1, -1, 0, 1'b1);
    wait_idle("restore_stuck");
    stuck = 1'b0;

    issue("step_out_trk0", CMD_STEP_OUT, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 0, 0, 0, 3, 0, 1'b1);
    wait_idle("step_out_trk0");
    issue("seek255", CMD_SEEK, 2'd0, 1'b0, 1'b0, 8'd255, 1'b1, 255, 255, 0, -1, 0, 1'b1);
    wait_idle("seek255");
    issue("step_in_sat", CMD_STEP_IN, 2'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1, 255, 0, -1, 0, 1'b1);
    wait_idle("step_in_sat");
    issue("step_out_settle", CMD_STEP_OUT, 2'd2, 1'b1, 1'b1, 8'd0, 1'b0, 1, 254, 0, -1, 0, 1'b1);
    wait_idle("step_out_settle");
    issue("step_held", CMD_STEP, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1, 254, 0, -1, 0, 1'b1);
    wait_idle("step_held");

    // Reset while STEPn is low in the middle of a seek.
    issue("seek_reset", CMD_SEEK, 2'd0, 1'b0, 1'b0, 8'd250, 1'b0, 0, 0, 0, -1, 0, 1'b0);
    n = 0;
    while (STEPn && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("seek_reset.pulse_seen", int'(STEPn), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("mid_pulse_reset");
    $display("txn seek_reset: STEPn=%0d busy=%0d cmd_ready=%0d", STEPn, busy, cmd_ready);
    @(posedge clk);
    #1 reset = 1'b0;

    issue("seek1_after_reset", CMD_SEEK, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1, 1, 0, -1, 0, 1'b1);
    wait_idle("seek1_after_reset");

    repeat (4) @(negedge clk);
    check("pending_done", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
